dmem_responder: RTL

Single-port data-memory responder serving the core's data-memory interface: accepts read/write requests, inserts configurable wait states on `ready`, and commits byte-strobed writes. It returns read data with a fixed latency and a `rdata_valid` pulse. It sits between the core's dmem port and on-chip SRAM, and is also the bench memory model for core regressions.

---
 rtl/dmem_if.sv | 33 +++
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// Core-side data-memory bus between the core's dmem port and dmem_responder.
// mem_err_o exists only when DMEM_OOR_ERR_EN is defined.
interface dmem_if;
  logic        mem_rd_i;
  logic        mem_wr_i;
  logic [3:0]  mem_strobe_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        mem_ready_o;
  logic [31:0] mem_rdata_o;
  logic        mem_rdata_valid_o;
`ifdef DMEM_OOR_ERR_EN
  logic        mem_err_o;

  modport master (
    output mem_rd_i, mem_wr_i, mem_strobe_i, mem_addr_i, mem_wdata_i,
    input  mem_ready_o, mem_rdata_o, mem_rdata_valid_o, mem_err_o
  );
  modport slave (
    input  mem_rd_i, mem_wr_i, mem_strobe_i, mem_addr_i, mem_wdata_i,
    output mem_ready_o, mem_rdata_o, mem_rdata_valid_o, mem_err_o
  );
`else
  modport master (
    output mem_rd_i, mem_wr_i, mem_strobe_i, mem_addr_i, mem_wdata_i,
    input  mem_ready_o, mem_rdata_o, mem_rdata_valid_o
  );
  modport slave (
    input  mem_rd_i, mem_wr_i, mem_strobe_i, mem_addr_i, mem_wdata_i,
    output mem_ready_o, mem_rdata_o, mem_rdata_valid_o
  );
`endif
endinterface

// File: rtl/dmem_responder.sv
// Single-port data-memory responder: wait states on ready, byte-strobed writes,
// fixed-latency reads. DMEM_OOR_ERR_EN adds out-of-range detection and mem_err_o.
module dmem_responder #(
  parameter int unsigned DEPTH        = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned WAIT_STATES  = 0,
  parameter int unsigned READ_LATENCY = 1
) (
  input logic   clk_i,
  input logic   rst_ni,
  dmem_if.slave bus
);
  localparam int unsigned AW        = $clog2(DEPTH);
  // The IDLE cycle that sees the request counts as the first wait state.
  localparam logic [3:0]  WCNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [2:0]  LCNT_LOAD = 3'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          oor;
  logic          req, ready, accept, accept_wr, accept_rd, idle_like;
  logic [31:0]   rd_word;
  logic          unused_addr_bits;

  state_e        state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic [2:0]    lcnt_q, lcnt_d;
  logic [31:0]   cap_q, cap_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          valid_q, valid_d;
`ifdef DMEM_OOR_ERR_EN
  logic          cap_oor_q, cap_oor_d;
  logic          err_q, err_d;
`endif

  assign req = bus.mem_rd_i | bus.mem_wr_i;
  assign off = bus.mem_addr_i - BASE_ADDR;
  assign idx = off[AW+1:2];

`ifdef DMEM_OOR_ERR_EN
  assign oor              = (bus.mem_addr_i < BASE_ADDR) || (off[31:AW+2] != '0);
  assign unused_addr_bits = ^off[1:0];
`else
  assign oor              = 1'b0;
  assign unused_addr_bits = ^{off[31:AW+2], off[1:0]};
`endif

  assign rd_word = oor ? '0 : mem_q[idx];

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    lcnt_d    = lcnt_q;
    cap_d     = cap_q;
    rdata_d   = rdata_q;
    valid_d   = 1'b0;
    ready     = 1'b0;
    accept    = 1'b0;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
`ifdef DMEM_OOR_ERR_EN
    cap_oor_d = cap_oor_q;
    err_d     = 1'b0;
`endif
    // The response cycle also serves a new request, allowing back-to-back reads.
    idle_like = (state_q == IDLE) || ((state_q == RESP) && (lcnt_q == '0));

    if (idle_like) begin
      state_d = IDLE;
      if (req) begin
        if (WAIT_STATES == 0) begin
          ready = 1'b1;
        end else begin
          state_d = WAIT;
          wcnt_d  = WCNT_LOAD;
        end
      end
    end else if (state_q == WAIT) begin
      if (!req) begin
        state_d = IDLE;
        wcnt_d  = '0;
      end else if (wcnt_q == '0) begin
        ready = 1'b1;
      end else begin
        wcnt_d = wcnt_q - 4'd1;
      end
    end else begin
      lcnt_d = lcnt_q - 3'd1;
    end

    accept    = req & ready;
    accept_wr = accept & bus.mem_wr_i;
    accept_rd = accept & ~bus.mem_wr_i;

    if (accept_wr) begin
      state_d = IDLE;
`ifdef DMEM_OOR_ERR_EN
      err_d   = oor;
`endif
    end else if (accept_rd) begin
      state_d = RESP;
      lcnt_d  = LCNT_LOAD;
      cap_d   = rd_word;
`ifdef DMEM_OOR_ERR_EN
      cap_oor_d = oor;
`endif
    end

    if ((state_d == RESP) && (lcnt_d == '0)) begin
      valid_d = 1'b1;
      rdata_d = cap_d;
`ifdef DMEM_OOR_ERR_EN
      err_d   = cap_oor_d;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      lcnt_q    <= '0;
      cap_q     <= '0;
      rdata_q   <= '0;
      valid_q   <= 1'b0;
`ifdef DMEM_OOR_ERR_EN
      cap_oor_q <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      lcnt_q    <= lcnt_d;
      cap_q     <= cap_d;
      rdata_q   <= rdata_d;
      valid_q   <= valid_d;
`ifdef DMEM_OOR_ERR_EN
      cap_oor_q <= cap_oor_d;
      err_q     <= err_d;
`endif
    end
  end

  // Array is deliberately not reset so it maps onto plain SRAM.
  always_ff @(posedge clk_i) begin
    if (accept_wr && !oor) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (bus.mem_strobe_i[b]) mem_q[idx][8*b +: 8] <= bus.mem_wdata_i[8*b +: 8];
      end
    end
  end

  assign bus.mem_ready_o       = ready;
  assign bus.mem_rdata_o       = rdata_q;
  assign bus.mem_rdata_valid_o = valid_q;
`ifdef DMEM_OOR_ERR_EN
  assign bus.mem_err_o         = err_q;
`endif
endmodule
